uart_frame_sched: RTL and testbench

- Command-driven transmit sequencer between the UART receiver/transmitter pair and the measurement counters.
- Decodes single-byte commands from the receiver.
- Snapshots Num_x, Num_s, cnt_high and cnt_low, then serialises them as an 18-byte framed packet through the transmitter's write/busy handshake.
- Supports one-shot and periodic streaming modes. Runs entirely in the UART clock domain (uart_clk output).

---
 rtl/uart_frame_sched.sv | 200 ++++++++++++++++++++
 tb/tb_uart_frame_sched.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sched.sv
// Command-driven UART transmit sequencer: snapshots four measurement words
// and sends them as an 18-byte framed packet, one-shot or periodically.
module uart_frame_sched #(
  parameter logic [15:0] PERIOD  = 16'd9600,
  parameter logic [3:0]  BUSY_TO = 4'd8
) (
  input  logic        Sys_CLK,
  input  logic        Sys_RST,
  input  logic        rdsig,
  input  logic [7:0]  rxdata,
  input  logic        rx_err,
  input  logic        tx_busy,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  input  logic [27:0] Num_x,
  input  logic [27:0] Num_s,
  input  logic [31:0] cnt_high,
  input  logic [31:0] cnt_low,
  output logic        streaming,
  output logic        frame_active,
  output logic [15:0] frame_cnt
);

  typedef enum logic [2:0] {
    IDLE, SNAP, LOAD, WAIT_RISE, WAIT_FALL, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [127:0]  shadow_q, shadow_d;
  logic [4:0]    idx_q, idx_d;
  logic [7:0]    csum_q, csum_d;
  logic [3:0]    to_q, to_d;
  logic [15:0]   per_q, per_d;
  logic          stream_q, stream_d;
  logic          pend_os_q, pend_os_d;
  logic          pend_per_q, pend_per_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          act_q, act_d;
  logic [15:0]   fcnt_q, fcnt_d;

  logic       cmd_ok, cmd_one, cmd_on, cmd_off;
  logic       tick, tick_eff, req;
  logic [3:0] slot;
  logic [7:0] cur_byte;

  assign cmd_ok  = rdsig & ~rx_err;
  assign cmd_one = cmd_ok & (rxdata == 8'h55);
  assign cmd_on  = cmd_ok & (rxdata == 8'hAA);
  assign cmd_off = cmd_ok & (rxdata == 8'h00);

  // A stop in the same cycle as a period expiry wins.
  assign tick_eff = tick & ~cmd_off;
  assign req      = cmd_one | tick_eff;

  always_comb begin
    stream_d = stream_q;
    per_d    = per_q;
    tick     = 1'b0;
    if (stream_q) begin
      if (per_q == PERIOD - 16'd1) begin
        tick  = 1'b1;
        per_d = 16'd0;
      end else begin
        per_d = per_q + 16'd1;
      end
    end
    if (cmd_on) begin
      stream_d = 1'b1;
      per_d    = 16'd0;
    end else if (cmd_off) begin
      stream_d = 1'b0;
      per_d    = 16'd0;
    end
  end

  // Payload index 1..16 maps to shadow bytes from the top down.
  assign slot = 4'(5'd16 - idx_q);

  always_comb begin
    if (idx_q == 5'd0) begin
      cur_byte = 8'hA5;
    end else if (idx_q == 5'd17) begin
      cur_byte = csum_q;
    end else begin
      cur_byte = shadow_q[{slot, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    to_d       = to_q;
    pend_os_d  = pend_os_q;
    pend_per_d = pend_per_q;
    tx_wr_d    = 1'b0;
    tx_data_d  = tx_data_q;
    act_d      = act_q;
    fcnt_d     = fcnt_q;
    case (state_q)
      IDLE: begin
        if (req | pend_os_q | pend_per_q) begin
          state_d    = SNAP;
          pend_os_d  = 1'b0;
          pend_per_d = 1'b0;
        end
      end
      SNAP: begin
        shadow_d = {4'h0, Num_x, 4'h0, Num_s, cnt_high, cnt_low};
        idx_d    = 5'd0;
        csum_d   = 8'd0;
        act_d    = 1'b1;
        state_d  = LOAD;
      end
      LOAD: begin
        if (!tx_busy) begin
          tx_wr_d   = 1'b1;
          tx_data_d = cur_byte;
          to_d      = 4'd0;
          state_d   = WAIT_RISE;
        end
      end
      WAIT_RISE: begin
        if (tx_busy) begin
          state_d = WAIT_FALL;
        end else if (to_q == BUSY_TO - 4'd1) begin
          state_d = LOAD;
        end else begin
          to_d = to_q + 4'd1;
        end
      end
      WAIT_FALL: begin
        if (!tx_busy) begin
          if (idx_q != 5'd0 && idx_q != 5'd17) begin
            csum_d = csum_q + tx_data_q;
          end
          if (idx_q == 5'd17) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        act_d   = 1'b0;
        fcnt_d  = fcnt_q + 16'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Requests during a frame collapse into one pending start.
    if (state_q != IDLE) begin
      if (cmd_one)  pend_os_d  = 1'b1;
      if (tick_eff) pend_per_d = 1'b1;
      if (cmd_off)  pend_per_d = 1'b0;
    end
  end

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      to_q       <= '0;
      per_q      <= '0;
      stream_q   <= 1'b0;
      pend_os_q  <= 1'b0;
      pend_per_q <= 1'b0;
      tx_wr_q    <= 1'b0;
      tx_data_q  <= '0;
      act_q      <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      to_q       <= to_d;
      per_q      <= per_d;
      stream_q   <= stream_d;
      pend_os_q  <= pend_os_d;
      pend_per_q <= pend_per_d;
      tx_wr_q    <= tx_wr_d;
      tx_data_q  <= tx_data_d;
      act_q      <= act_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign tx_wr        = tx_wr_q;
  assign tx_data      = tx_data_q;
  assign streaming    = stream_q;
  assign frame_active = act_q;
  assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed/randomized bench for uart_frame_sched with a transmitter model
// and a packet-level reference model.
module tb_uart_frame_sched;

  logic        Sys_CLK = 1'b0;
  logic        Sys_RST = 1'b1;
  logic        rdsig = 1'b0;
  logic [7:0]  rxdata = 8'h00;
  logic        rx_err = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_wr;
  logic [7:0]  tx_data;
  logic [27:0] Num_x = '0;
  logic [27:0] Num_s = '0;
  logic [31:0] cnt_high = '0;
  logic [31:0] cnt_low = '0;
  logic        streaming;
  logic        frame_active;
  logic [15:0] frame_cnt;

  uart_frame_sched #(.PERIOD(16'd400), .BUSY_TO(4'd8)) dut (
    .Sys_CLK(Sys_CLK), .Sys_RST(Sys_RST),
    .rdsig(rdsig), .rxdata(rxdata), .rx_err(rx_err),
    .tx_busy(tx_busy), .tx_wr(tx_wr), .tx_data(tx_data),
    .Num_x(Num_x), .Num_s(Num_s),
    .cnt_high(cnt_high), .cnt_low(cnt_low),
    .streaming(streaming), .frame_active(frame_active),
    .frame_cnt(frame_cnt)
  );

  always #5 Sys_CLK = ~Sys_CLK;

  int vectors = 0;
  int miscompares = 0;

  // Transmitter model and activity recorder.
  longint     cyc = 0;
  int         busy_cnt = 0;
  int         busy_len = 20;
  bit         ignore_next = 1'b0;
  int         ignored = 0;
  int         busy_viol = 0;
  int         stab_viol = 0;
  logic [7:0] cur = '0;
  logic       fa_prev = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] wr_data[$];
  longint     wr_time[$];
  longint     starts[$];
  longint     ends[$];

  always @(posedge Sys_CLK) begin
    cyc++;
    if (frame_active && !fa_prev) starts.push_back(cyc);
    if (!frame_active && fa_prev) ends.push_back(cyc);
    fa_prev = frame_active;
    if (tx_wr) begin
      wr_data.push_back(tx_data);
      wr_time.push_back(cyc);
      if (tx_busy) begin
        busy_viol++;
      end else if (ignore_next) begin
        ignore_next = 1'b0;
        ignored++;
      end else begin
        tx_busy <= 1'b1;
        busy_cnt = busy_len;
        cur = tx_data;
        rx_q.push_back(tx_data);
      end
    end else if (tx_busy) begin
      if (tx_data !== cur) stab_viol++;
      busy_cnt--;
      if (busy_cnt == 0) tx_busy <= 1'b0;
    end
  end

  // Reference packet: header, four big-endian words, byte-sum checksum.
  logic [7:0] exp_q[$];

  task automatic build_exp(input logic [27:0] x, input logic [27:0] s,
                           input logic [31:0] h, input logic [31:0] l);
    logic [31:0] w[4];
    logic [7:0]  sum;
    w[0] = {4'h0, x};
    w[1] = {4'h0, s};
    w[2] = h;
    w[3] = l;
    sum = 8'd0;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) begin
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(w[i][8*b +: 8]);
        sum = sum + w[i][8*b +: 8];
      end
    end
    exp_q.push_back(sum);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_frame(input string tag, input int base);
    logic [31:0] got;
    for (int i = 0; i < 18; i++) begin
      got = (base + i < rx_q.size()) ? {24'h0, rx_q[base + i]} : 32'hDEAD;
      chk($sformatf("%s_b%0d", tag, i), got, {24'h0, exp_q[i]});
    end
  endtask

  task automatic send(input logic [7:0] b, input logic e);
    @(negedge Sys_CLK);
    rdsig = 1'b1;
    rxdata = b;
    rx_err = e;
    @(negedge Sys_CLK);
    rdsig = 1'b0;
    rx_err = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input logic [15:0] target,
                             input int budget);
    int n;
    n = 0;
    while (frame_cnt !== target && n < budget) begin
      @(negedge Sys_CLK);
      n++;
    end
    chk(tag, {16'h0, frame_cnt}, {16'h0, target});
  endtask

  task automatic rand_inputs();
    Num_x = 28'($urandom);
    Num_s = 28'($urandom);
    cnt_high = $urandom;
    cnt_low = $urandom;
  endtask

  initial begin
    int rb, wb, n;
    logic [15:0] cb;
    logic [7:0] b;
    logic e;

    // Reset values
    @(negedge Sys_CLK);
    chk("rst_tx_wr", {31'h0, tx_wr}, 32'd0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'd0);
    chk("rst_streaming", {31'h0, streaming}, 32'd0);
    chk("rst_active", {31'h0, frame_active}, 32'd0);
    chk("rst_frame_cnt", {16'h0, frame_cnt}, 32'd0);
    @(negedge Sys_CLK);
    Sys_RST = 1'b0;
    repeat (3) @(negedge Sys_CLK);

    // Directed one-shot frame, inputs disturbed mid-frame
    busy_len = 20;
    Num_x = 28'h1234567;
    Num_s = 28'h0ABCDEF;
    cnt_high = 32'h00000010;
    cnt_low = 32'hFFFFFFFF;
    build_exp(Num_x, Num_s, cnt_high, cnt_low);
    rb = rx_q.size();
    send(8'h55, 1'b0);
    n = 0;
    while (!frame_active && n < 20) begin
      @(negedge Sys_CLK);
      n++;
    end
    chk("os_active", {31'h0, frame_active}, 32'd1);
    rand_inputs();
    wait_frames("os_done", 16'd1, 1000);
    @(negedge Sys_CLK);
    check_frame("os", rb);
    chk("os_active_low", {31'h0, frame_active}, 32'd0);

    // Errored command and random non-command bytes are ignored
    wb = wr_data.size();
    send(8'h55, 1'b1);
    send(8'h33, 1'b0);
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      e = 1'($urandom);
      if (!e && (b == 8'h55 || b == 8'hAA || b == 8'h00)) b = 8'h33;
      send(b, e);
    end
    repeat (100) @(negedge Sys_CLK);
    chk("ign_no_wr", 32'(wr_data.size() - wb), 32'd0);
    chk("ign_streaming", {31'h0, streaming}, 32'd0);
    chk("ign_frame_cnt", {16'h0, frame_cnt}, 32'd1);

    // Transmitter drops the first write: same byte re-pulsed
    busy_len = 5;
    rand_inputs();
    build_exp(Num_x, Num_s, cnt_high, cnt_low);
    rb = rx_q.size();
    wb = wr_data.size();
    ignore_next = 1'b1;
    send(8'h55, 1'b0);
    wait_frames("to_done", 16'd2, 1000);
    chk("to_ignored", ignored, 32'd1);
    chk("to_first", {24'h0, wr_data[wb]}, 32'h000000A5);
    chk("to_repulse", {24'h0, wr_data[wb + 1]}, 32'h000000A5);
    chk("to_gap_ok",
        {31'h0, (wr_time[wb + 1] - wr_time[wb] >= 8) &&
                (wr_time[wb + 1] - wr_time[wb] <= 10)}, 32'd1);
    check_frame("to", rb);

    // Streaming with frames shorter than the period
    rand_inputs();
    build_exp(Num_x, Num_s, cnt_high, cnt_low);
    rb = rx_q.size();
    cb = frame_cnt;
    starts.delete();
    send(8'hAA, 1'b0);
    chk("str_on", {31'h0, streaming}, 32'd1);
    n = 0;
    while (starts.size() < 3 && n < 2000) begin
      @(negedge Sys_CLK);
      n++;
    end
    chk("str_starts", starts.size(), 32'd3);
    chk("str_gap1", 32'(starts[1] - starts[0]), 32'd400);
    chk("str_gap2", 32'(starts[2] - starts[1]), 32'd400);
    send(8'h00, 1'b0);
    chk("str_mid_active", {31'h0, frame_active}, 32'd1);
    wait_frames("str_last", 16'(cb + 16'd3), 1000);
    repeat (900) @(negedge Sys_CLK);
    chk("str_cnt", {16'h0, frame_cnt}, {16'h0, 16'(cb + 16'd3)});
    chk("str_nstarts", starts.size(), 32'd3);
    chk("str_off", {31'h0, streaming}, 32'd0);
    chk("str_bytes", 32'(rx_q.size() - rb), 32'd54);
    for (int f = 0; f < 3; f++) check_frame($sformatf("str%0d", f), rb + 18 * f);

    // Overrun: frames longer than the period run back to back
    busy_len = 20;
    rand_inputs();
    build_exp(Num_x, Num_s, cnt_high, cnt_low);
    rb = rx_q.size();
    cb = frame_cnt;
    starts.delete();
    ends.delete();
    send(8'hAA, 1'b0);
    n = 0;
    while (starts.size() < 5 && n < 4000) begin
      @(negedge Sys_CLK);
      n++;
    end
    chk("ovr_starts", starts.size(), 32'd5);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("ovr_b2b%0d", i),
          {31'h0, (starts[i] > ends[i-1]) && (starts[i] - ends[i-1] <= 4)},
          32'd1);
    end
    // One-shot pending survives a stop; periodic pending does not.
    send(8'h55, 1'b0);
    send(8'h00, 1'b0);
    n = starts.size();
    wait_frames("ovr_last", 16'(cb + 16'(n + 1)), 2000);
    repeat (1200) @(negedge Sys_CLK);
    chk("ovr_cnt", {16'h0, frame_cnt}, {16'h0, 16'(cb + 16'(n + 1))});
    chk("ovr_nstarts", starts.size(), 32'(n + 1));
    chk("ovr_bytes", 32'(rx_q.size() - rb), 32'(18 * (n + 1)));
    chk("ovr_off", {31'h0, streaming}, 32'd0);
    for (int f = 0; f < n + 1; f++) check_frame($sformatf("ovr%0d", f), rb + 18 * f);

    // Asynchronous reset while byte 7 is being written
    rand_inputs();
    wb = wr_data.size();
    send(8'hAA, 1'b0);
    send(8'h55, 1'b0);
    n = 0;
    while (!(wr_data.size() >= wb + 7 && tx_wr) && n < 2000) begin
      @(negedge Sys_CLK);
      n++;
    end
    chk("ar_reach", {31'h0, tx_wr}, 32'd1);
    #2;
    Sys_RST = 1'b1;
    #1;
    chk("ar_tx_wr", {31'h0, tx_wr}, 32'd0);
    chk("ar_active", {31'h0, frame_active}, 32'd0);
    chk("ar_streaming", {31'h0, streaming}, 32'd0);
    chk("ar_cnt", {16'h0, frame_cnt}, 32'd0);
    repeat (3) @(negedge Sys_CLK);
    Sys_RST = 1'b0;
    repeat (30) @(negedge Sys_CLK);
    rand_inputs();
    build_exp(Num_x, Num_s, cnt_high, cnt_low);
    rb = rx_q.size();
    send(8'h55, 1'b0);
    wait_frames("ar_frame", 16'd1, 1000);
    check_frame("ar", rb);
    chk("ar_stream_after", {31'h0, streaming}, 32'd0);

    chk("busy_writes", busy_viol, 32'd0);
    chk("data_stable", stab_viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
